// File: rtl/csr_uart_pkg.sv
// Shared CSR offsets, STATUS bit positions and FSM state types for the
// buffered CSR UART.
package csr_uart_pkg;

   localparam logic [11:0] OFS_DATA    = 12'd0;
   localparam logic [11:0] OFS_STATUS  = 12'd1;
   localparam logic [11:0] OFS_DIVISOR = 12'd2;

   localparam int ST_RX_IE     = 0;
   localparam int ST_TX_IE     = 1;
   localparam int ST_RX_OVF    = 2;
   localparam int ST_FRAME_ERR = 3;
   localparam int ST_TX_OVF    = 4;

   localparam int MOD_WRITE = 0;
   localparam int MOD_SET   = 1;
   localparam int MOD_CLEAR = 2;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   function automatic logic [31:0] csr_modify(input logic [2:0]  modify,
                                              input logic [31:0] old_val,
                                              input logic [31:0] wdata);
      if (modify[MOD_WRITE])      return wdata;
      else if (modify[MOD_SET])   return old_val | wdata;
      else if (modify[MOD_CLEAR]) return old_val & ~wdata;
      else                        return old_val;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = count[DEPTH_LOG2];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
   end

endmodule

// File: rtl/csr_uart_fifo.sv
// Buffered 8N1 UART CSR slave: DATA / STATUS / DIVISOR registers, TX and RX
// FIFOs, run-time baud divisor latched per frame, sticky error flags.
//
// tx state     | meaning
// TX_IDLE      | line high, pops the next byte when TX FIFO non-empty
// TX_START     | start bit (low) for one divisor period
// TX_DATA      | eight data bits, LSB first
// TX_STOP      | stop bit (high)
//
// rx state     | meaning
// RX_IDLE      | waiting for a low level on the synchronised input
// RX_START     | half-period wait, then start bit re-check (glitch filter)
// RX_DATA      | eight data samples, one per divisor period
// RX_STOP      | stop sample: push byte or flag a framing error
// RX_WAIT_HIGH | after a framing error, wait for the line to return high
module csr_uart_fifo
   import csr_uart_pkg::*;
#(
   parameter logic [11:0] BASE_ADDR       = 12'hBC0,
   parameter int          CLOCK_RATE      = 50_000_000,
   parameter int          BAUD_RATE       = 115200,
   parameter int          FIFO_DEPTH_LOG2 = 4,
   parameter int          DIV_WIDTH       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic [2:0]  modify,
   input  logic [31:0] wdata,
   input  logic [11:0] addr,
   output logic [31:0] rdata,
   output logic        valid,
   input  logic        rx,
   output logic        tx,
   output logic        irq
);

   localparam int                   CW        = FIFO_DEPTH_LOG2 + 1;
   localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(CLOCK_RATE / BAUD_RATE);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(2);

   logic hit_data, hit_status, hit_div, wr_any;
   logic [4:0]           ctrl_q, ctrl_nxt;
   logic [DIV_WIDTH-1:0] div_q, div_nxt;
   logic [31:0]          ctrl_mod, div_mod;

   logic          tx_push, tx_pop, tx_empty, tx_full, tx_ovf_set;
   logic [7:0]    tx_dout;
   logic [CW-1:0] tx_count;
   logic          rx_push, rx_pop, rx_empty, rx_full, rx_ovf_set, frame_err_set;
   logic [7:0]    rx_dout;
   logic [CW-1:0] rx_count;
   logic [7:0]    tx_cnt8, rx_cnt8;

   tx_state_t            tx_state;
   logic [DIV_WIDTH-1:0] tx_timer, tx_div;
   logic [7:0]           tx_shift;
   logic [2:0]           tx_bit;
   logic                 tx_busy;

   rx_state_t            rx_state;
   logic [DIV_WIDTH-1:0] rx_timer, rx_div;
   logic [7:0]           rx_shift;
   logic [2:0]           rx_bit;
   logic                 rx_s1, rx_s2, rx_tc;
   logic                 unused_bits;

   assign hit_data   = (addr == BASE_ADDR + OFS_DATA);
   assign hit_status = (addr == BASE_ADDR + OFS_STATUS);
   assign hit_div    = (addr == BASE_ADDR + OFS_DIVISOR);
   assign valid      = hit_data | hit_status | hit_div;
   assign wr_any     = |modify;

   assign tx_push    = hit_data & wr_any;
   assign tx_pop     = (tx_state == TX_IDLE) & ~tx_empty;
   assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
   assign tx_busy    = (tx_state != TX_IDLE);

   assign rx_pop        = hit_data & read & ~rx_empty;
   assign rx_tc         = (rx_timer == '0);
   assign rx_push       = (rx_state == RX_STOP) & rx_tc & rx_s2;
   assign frame_err_set = (rx_state == RX_STOP) & rx_tc & ~rx_s2;
   assign rx_ovf_set    = rx_push & rx_full & ~rx_pop;

   assign tx_cnt8 = 8'(tx_count);
   assign rx_cnt8 = 8'(rx_count);
   assign irq     = (~rx_empty & ctrl_q[ST_RX_IE]) | (tx_empty & ctrl_q[ST_TX_IE]);

   sync_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(wdata[7:0]),
      .dout(tx_dout), .empty(tx_empty), .full(tx_full), .count(tx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_shift),
      .dout(rx_dout), .empty(rx_empty), .full(rx_full), .count(rx_count)
   );

   always_comb begin
      rdata = '0;
      if (hit_data)
         rdata = {22'b0, tx_full, rx_empty, rx_empty ? 8'h00 : rx_dout};
      else if (hit_status)
         rdata = {7'b0, tx_busy, tx_cnt8, rx_cnt8, 3'b0, ctrl_q};
      else if (hit_div)
         rdata = 32'(div_q);
   end

   // Hardware flag sets are ORed in last so they win over a software clear.
   always_comb begin
      ctrl_mod = csr_modify(modify, 32'(ctrl_q), wdata);
      div_mod  = csr_modify(modify, 32'(div_q), wdata);
      ctrl_nxt = ctrl_q;
      div_nxt  = div_q;
      if (hit_status && wr_any) ctrl_nxt = ctrl_mod[4:0];
      if (hit_div && wr_any)
         div_nxt = (div_mod[DIV_WIDTH-1:0] < DIV_MIN) ? DIV_MIN : div_mod[DIV_WIDTH-1:0];
      ctrl_nxt[ST_RX_OVF]    = ctrl_nxt[ST_RX_OVF] | rx_ovf_set;
      ctrl_nxt[ST_FRAME_ERR] = ctrl_nxt[ST_FRAME_ERR] | frame_err_set;
      ctrl_nxt[ST_TX_OVF]    = ctrl_nxt[ST_TX_OVF] | tx_ovf_set;
   end

   assign unused_bits = ^{ctrl_mod, div_mod, wdata};

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= '0;
         div_q  <= DIV_RESET;
      end else begin
         ctrl_q <= ctrl_nxt;
         div_q  <= div_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx       <= 1'b1;
         tx_timer <= '0;
         tx_div   <= DIV_RESET;
         tx_shift <= '0;
         tx_bit   <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: if (!tx_empty) begin
               tx_shift <= tx_dout;
               tx_div   <= div_q;
               tx_timer <= div_q - DIV_ONE;
               tx       <= 1'b0;
               tx_state <= TX_START;
            end
            TX_START: if (tx_timer == '0) begin
               tx_timer <= tx_div - DIV_ONE;
               tx       <= tx_shift[0];
               tx_shift <= {1'b0, tx_shift[7:1]};
               tx_bit   <= '0;
               tx_state <= TX_DATA;
            end else tx_timer <= tx_timer - DIV_ONE;
            TX_DATA: if (tx_timer == '0) begin
               tx_timer <= tx_div - DIV_ONE;
               if (tx_bit == 3'd7) begin
                  tx       <= 1'b1;
                  tx_state <= TX_STOP;
               end else begin
                  tx       <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_bit   <= tx_bit + 3'd1;
               end
            end else tx_timer <= tx_timer - DIV_ONE;
            TX_STOP: if (tx_timer == '0) tx_state <= TX_IDLE;
                     else tx_timer <= tx_timer - DIV_ONE;
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_state <= RX_IDLE;
         rx_timer <= '0;
         rx_div   <= DIV_RESET;
         rx_shift <= '0;
         rx_bit   <= '0;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         case (rx_state)
            RX_IDLE: if (!rx_s2) begin
               rx_div   <= div_q;
               rx_timer <= (div_q >> 1) - DIV_ONE;
               rx_state <= RX_START;
            end
            RX_START: if (rx_tc) begin
               if (rx_s2) rx_state <= RX_IDLE;
               else begin
                  rx_timer <= rx_div - DIV_ONE;
                  rx_bit   <= '0;
                  rx_state <= RX_DATA;
               end
            end else rx_timer <= rx_timer - DIV_ONE;
            RX_DATA: if (rx_tc) begin
               rx_shift <= {rx_s2, rx_shift[7:1]};
               rx_timer <= rx_div - DIV_ONE;
               if (rx_bit == 3'd7) rx_state <= RX_STOP;
               else rx_bit <= rx_bit + 3'd1;
            end else rx_timer <= rx_timer - DIV_ONE;
            RX_STOP: if (rx_tc) rx_state <= rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
                     else rx_timer <= rx_timer - DIV_ONE;
            RX_WAIT_HIGH: if (rx_s2) rx_state <= RX_IDLE;
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_uart_fifo.sv
// Self-checking bench for csr_uart_fifo: register vector table, serial
// framing, loopback against a byte-queue model, and error/irq/reset corners.
module tb_csr_uart_fifo;

   localparam logic [11:0] A_DATA = 12'hBC0;
   localparam logic [11:0] A_STAT = 12'hBC1;
   localparam logic [11:0] A_DIV  = 12'hBC2;

   typedef struct {
      logic        rd;
      logic [2:0]  md;
      logic [31:0] wd;
      logic [11:0] ad;
      logic [31:0] exp_rdata;
      logic        exp_valid;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        read = 1'b0;
   logic [2:0]  modify = 3'b000;
   logic [31:0] wdata = 32'h0;
   logic [11:0] addr = 12'h0;
   logic [31:0] rdata;
   logic        valid, tx, irq, rx;
   logic        rx_drv = 1'b1;
   logic        loopback = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   assign rx = loopback ? tx : rx_drv;

   always #5 clk = ~clk;

   csr_uart_fifo dut (
      .clk(clk), .rst(rst), .read(read), .modify(modify), .wdata(wdata),
      .addr(addr), .rdata(rdata), .valid(valid), .rx(rx), .tx(tx), .irq(irq)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One bus cycle: drive at negedge, sample combinational read data, commit on posedge.
   task automatic csr_op(input logic rd, input logic [2:0] md, input logic [31:0] wd,
                         input logic [11:0] ad, output logic [31:0] r, output logic v);
      @(negedge clk);
      read = rd; modify = md; wdata = wd; addr = ad;
      #1;
      r = rdata;
      v = valid;
      @(posedge clk);
      #1;
      read = 1'b0; modify = 3'b000; wdata = 32'h0; addr = 12'h0;
   endtask

   task automatic wait_rx_count(input int n, input int budget);
      logic [31:0] s;
      logic v;
      int k = 0;
      do begin
         csr_op(1'b1, 3'b000, 32'h0, A_STAT, s, v);
         k++;
      end while (s[15:8] != n[7:0] && k < budget);
      check("rx_count_wait", 64'(s[15:8]), 64'(n[7:0]));
   endtask

   task automatic wait_tx_idle(input int budget);
      logic [31:0] s;
      logic v;
      int k = 0;
      do begin
         csr_op(1'b1, 3'b000, 32'h0, A_STAT, s, v);
         k++;
      end while (s[24:16] != 9'h0 && k < budget);
      check("tx_idle_wait", 64'(s[24:16]), 64'h0);
   endtask

   task automatic drive_rx_frame(input logic [7:0] b, input logic stop, input int div);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rx_drv = bits[i];
         repeat (div - 1) @(negedge clk);
      end
      @(negedge clk);
      rx_drv = 1'b1;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[22];
      logic [31:0] r;
      logic        v;
      logic [9:0]  frame;
      logic [39:0] got, exp_w;
      logic [7:0]  q[$];
      logic [7:0]  b;
      logic [15:0] div_m, nv;
      logic [31:0] wd;
      logic [2:0]  md;
      int          k, d, n, op;

      vecs[0]  = '{1'b1, 3'b000, 32'h0,        A_DIV,   32'd434,    1'b1};
      vecs[1]  = '{1'b1, 3'b000, 32'h0,        12'h300, 32'h0,      1'b0};
      vecs[2]  = '{1'b1, 3'b000, 32'h0,        A_STAT,  32'h0,      1'b1};
      vecs[3]  = '{1'b1, 3'b000, 32'h0,        A_DATA,  32'h100,    1'b1};
      vecs[4]  = '{1'b0, 3'b001, 32'h1,        A_DIV,   32'd434,    1'b1};
      vecs[5]  = '{1'b1, 3'b000, 32'h0,        A_DIV,   32'd2,      1'b1};
      vecs[6]  = '{1'b0, 3'b010, 32'h10,       A_DIV,   32'd2,      1'b1};
      vecs[7]  = '{1'b1, 3'b000, 32'h0,        A_DIV,   32'h12,     1'b1};
      vecs[8]  = '{1'b0, 3'b100, 32'h2,        A_DIV,   32'h12,     1'b1};
      vecs[9]  = '{1'b1, 3'b000, 32'h0,        A_DIV,   32'h10,     1'b1};
      vecs[10] = '{1'b0, 3'b001, 32'hABCDE,    A_DIV,   32'h10,     1'b1};
      vecs[11] = '{1'b1, 3'b000, 32'h0,        A_DIV,   32'hBCDE,   1'b1};
      vecs[12] = '{1'b0, 3'b100, 32'hFFFF,     A_DIV,   32'hBCDE,   1'b1};
      vecs[13] = '{1'b1, 3'b000, 32'h0,        A_DIV,   32'd2,      1'b1};
      vecs[14] = '{1'b0, 3'b001, 32'hFFFFFFE3, A_STAT,  32'h0,      1'b1};
      vecs[15] = '{1'b1, 3'b000, 32'h0,        A_STAT,  32'h3,      1'b1};
      vecs[16] = '{1'b0, 3'b010, 32'h1C,       A_STAT,  32'h3,      1'b1};
      vecs[17] = '{1'b1, 3'b000, 32'h0,        A_STAT,  32'h1F,     1'b1};
      vecs[18] = '{1'b0, 3'b100, 32'hFFFFFFFF, A_STAT,  32'h1F,     1'b1};
      vecs[19] = '{1'b1, 3'b000, 32'h0,        A_STAT,  32'h0,      1'b1};
      vecs[20] = '{1'b1, 3'b000, 32'h0,        12'hBC3, 32'h0,      1'b0};
      vecs[21] = '{1'b1, 3'b000, 32'h0,        12'hBBF, 32'h0,      1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_tx", 64'(tx), 64'h1);
      check("reset_irq", 64'(irq), 64'h0);
      check("reset_rdata", 64'(rdata), 64'h0);
      check("reset_valid", 64'(valid), 64'h0);

      foreach (vecs[i]) begin
         csr_op(vecs[i].rd, vecs[i].md, vecs[i].wd, vecs[i].ad, r, v);
         check($sformatf("vec%0d_rdata", i), 64'(r), 64'(vecs[i].exp_rdata));
         check($sformatf("vec%0d_valid", i), 64'(v), 64'(vecs[i].exp_valid));
      end

      // Single frame: each line level must last exactly DIVISOR clocks.
      csr_op(1'b0, 3'b001, 32'd4, A_DIV, r, v);
      csr_op(1'b0, 3'b001, 32'h1A5, A_DATA, r, v);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (tx !== 1'b0 && k < 20);
      check("tx_start_seen", 64'(tx), 64'h0);
      frame = {1'b1, 8'hA5, 1'b0};
      for (int s = 0; s < 40; s++) exp_w[s] = frame[s / 4];
      got[0] = tx;
      for (int s = 1; s < 40; s++) begin
         @(negedge clk);
         got[s] = tx;
      end
      check("tx_pattern_A5", 64'(got), 64'(exp_w));
      @(negedge clk);
      check("tx_idle_after_frame", 64'(tx), 64'h1);

      // Loopback fill of the RX FIFO and one overflow byte.
      loopback = 1'b1;
      for (int i = 0; i < 16; i++) csr_op(1'b0, 3'b001, 32'(i), A_DATA, r, v);
      wait_rx_count(16, 1500);
      csr_op(1'b1, 3'b000, 32'h0, A_STAT, r, v);
      check("lb_full_no_ovf", 64'({r[15:8], r[2]}), 64'({8'd16, 1'b0}));
      csr_op(1'b0, 3'b001, 32'h10, A_DATA, r, v);
      wait_tx_idle(200);
      repeat (20) @(posedge clk);
      csr_op(1'b1, 3'b000, 32'h0, A_STAT, r, v);
      check("lb_rx_ovf", 64'({r[15:8], r[2]}), 64'({8'd16, 1'b1}));
      for (int i = 0; i < 16; i++) begin
         csr_op(1'b1, 3'b000, 32'h0, A_DATA, r, v);
         check($sformatf("lb_data%0d", i), 64'(r), 64'(i));
      end
      csr_op(1'b1, 3'b000, 32'h0, A_DATA, r, v);
      check("lb_drained_empty", 64'(r[8]), 64'h1);
      csr_op(1'b0, 3'b100, 32'h1C, A_STAT, r, v);

      // Random write/set/clear on DIVISOR against an arithmetic model.
      div_m = 16'd4;
      for (int it = 0; it < 12; it++) begin
         op = int'($urandom_range(0, 3));
         wd = $urandom;
         md = (op == 0) ? 3'b000 : 3'(1 << (op - 1));
         csr_op(1'b0, md, wd, A_DIV, r, v);
         case (op)
            1:       nv = wd[15:0];
            2:       nv = div_m | wd[15:0];
            3:       nv = div_m & ~wd[15:0];
            default: nv = div_m;
         endcase
         if (nv < 16'd2) nv = 16'd2;
         div_m = nv;
         csr_op(1'b1, 3'b000, 32'h0, A_DIV, r, v);
         check($sformatf("div_rand%0d", it), 64'(r), 64'(div_m));
      end

      // Random loopback rounds checked against a byte queue.
      for (int rnd = 0; rnd < 3; rnd++) begin
         d = int'($urandom_range(2, 10));
         n = int'($urandom_range(1, 16));
         csr_op(1'b0, 3'b001, 32'(d), A_DIV, r, v);
         q.delete();
         for (int j = 0; j < n; j++) begin
            b = 8'($urandom_range(0, 255));
            q.push_back(b);
            csr_op(1'b0, 3'b001, {24'h0, b}, A_DATA, r, v);
         end
         wait_tx_idle(n * (10 * d + 2) + 50);
         repeat (3 * d + 10) @(posedge clk);
         csr_op(1'b1, 3'b000, 32'h0, A_STAT, r, v);
         check($sformatf("rnd%0d_status", rnd), 64'({r[15:8], r[3], r[2]}), 64'({n[7:0], 2'b00}));
         for (int j = 0; j < n; j++) begin
            csr_op(1'b1, 3'b000, 32'h0, A_DATA, r, v);
            b = q.pop_front();
            check($sformatf("rnd%0d_byte%0d", rnd, j), 64'(r), 64'(b));
         end
      end
      loopback = 1'b0;

      // Bad stop bit: flag set, byte discarded, then software clear.
      csr_op(1'b0, 3'b001, 32'd8, A_DIV, r, v);
      repeat (5) @(posedge clk);
      drive_rx_frame(8'h3C, 1'b0, 8);
      repeat (20) @(posedge clk);
      csr_op(1'b1, 3'b000, 32'h0, A_STAT, r, v);
      check("frame_err_set", 64'({r[15:8], r[3]}), 64'({8'd0, 1'b1}));
      csr_op(1'b0, 3'b100, 32'h8, A_STAT, r, v);
      csr_op(1'b1, 3'b000, 32'h0, A_STAT, r, v);
      check("frame_err_cleared", 64'(r[3]), 64'h0);

      // Two-cycle low glitch must be rejected; receiver stays usable.
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (2) @(negedge clk);
      rx_drv = 1'b1;
      repeat (40) @(posedge clk);
      csr_op(1'b1, 3'b000, 32'h0, A_STAT, r, v);
      check("glitch_ignored", 64'(r[15:0]), 64'h0);
      drive_rx_frame(8'h5A, 1'b1, 8);
      repeat (20) @(posedge clk);
      csr_op(1'b1, 3'b000, 32'h0, A_DATA, r, v);
      check("rx_after_glitch", 64'(r), 64'h5A);

      // tx_ie interrupt, TX FIFO fill boundary and overflow.
      csr_op(1'b0, 3'b001, 32'd434, A_DIV, r, v);
      csr_op(1'b0, 3'b010, 32'h2, A_STAT, r, v);
      check("irq_tx_empty", 64'(irq), 64'h1);
      for (int i = 0; i < 17; i++) csr_op(1'b0, 3'b001, 32'h0, A_DATA, r, v);
      check("irq_tx_nonempty", 64'(irq), 64'h0);
      csr_op(1'b1, 3'b000, 32'h0, A_STAT, r, v);
      check("tx_fill16", 64'({r[24:16], r[4]}), 64'({1'b1, 8'd16, 1'b0}));
      csr_op(1'b1, 3'b000, 32'h0, A_DATA, r, v);
      check("data_full_flags", 64'(r[9:8]), 64'h3);
      csr_op(1'b0, 3'b001, 32'h0, A_DATA, r, v);
      csr_op(1'b1, 3'b000, 32'h0, A_STAT, r, v);
      check("tx_ovf_set", 64'({r[23:16], r[4]}), 64'({8'd16, 1'b1}));

      // Reset in the middle of a frame.
      check("tx_low_before_rst", 64'(tx), 64'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("tx_high_after_rst", 64'(tx), 64'h1);
      rst = 1'b0;
      csr_op(1'b1, 3'b000, 32'h0, A_STAT, r, v);
      check("status_after_rst", 64'(r), 64'h0);
      csr_op(1'b1, 3'b000, 32'h0, A_DIV, r, v);
      check("div_after_rst", 64'(r), 64'd434);
      check("irq_after_rst", 64'(irq), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
